alu_operand_stage: RTL and testbench

- Parametrised successor to the single 32-bit ALU operand register.
- Latches NUM_OPS operands of WIDTH bits plus a tag into the ALU input stage, using a valid/ready handshake.
- A 2-entry skid buffer lets decode/issue keep streaming while the ALU stalls.
- Supports synchronous pipeline flush for branch/exception squash; sits between register-read and ALU.

---
 rtl/alu_operand_stage.sv | 150 +++++++++++++++
 tb/tb_alu_operand_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage
// Purpose  : ALU input stage. Latches NUM_OPS operands of WIDTH bits plus a
//            sideband tag behind a valid/ready handshake. A main register
//            drives the ALU and a skid register absorbs one extra entry, so
//            decode/issue can keep streaming while the ALU stalls. A
//            synchronous flush squashes every buffered entry.
// Ports    : clk, rst (async, active-high), flush
//            in_valid / in_ready / in_data / in_tag    upstream side
//            out_valid / out_ready / out_data / out_tag  ALU side
//            occupancy                                   entries held (0..2)
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
  parameter int               WIDTH     = 32,
  parameter int               NUM_OPS   = 2,
  parameter int               TAG_W     = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OPS*WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_OPS*WIDTH-1:0] out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic [1:0]               occupancy
);

  localparam int                     DATA_W   = NUM_OPS * WIDTH;
  localparam logic [DATA_W-1:0]      DATA_RST = {NUM_OPS{RESET_VAL}};
  localparam logic [TAG_W-1:0]       TAG_RST  = TAG_W'(RESET_VAL);

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [DATA_W-1:0]   main_data;
  logic [TAG_W-1:0]    main_tag;
  logic [DATA_W-1:0]   skid_data;
  logic [TAG_W-1:0]    skid_tag;

  logic                in_fire;
  logic                out_fire;
  logic                load_main_in;
  logic                load_main_skid;
  logic                load_skid;

  // Handshake outputs decode only registered state.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign out_data  = main_data;
  assign out_tag   = main_tag;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // --------------------------------------------------------------------------
  // Next-state and register-load decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      // Squash wins over everything; a concurrent input is dropped and a
      // concurrent ALU consume is simply not re-presented.
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            load_main_in = 1'b1;
            state_nxt    = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain path exists.
          if (out_fire) begin
            load_main_skid = 1'b1;
            state_nxt      = ONE;
          end
        end
        default: begin
          state_nxt = EMPTY;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Data/tag registers. Flush only clears the state; payload may go stale.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data <= DATA_RST;
      main_tag  <= TAG_RST;
      skid_data <= DATA_RST;
      skid_tag  <= TAG_RST;
    end else begin
      if (load_main_in) begin
        main_data <= in_data;
        main_tag  <= in_tag;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_tag  <= skid_tag;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_tag  <= in_tag;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_stage
// Purpose  : Directed and seeded-random self-checking bench for
//            alu_operand_stage, including two extra parameterisations for
//            the lane-mapping sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

  typedef struct packed {
    logic [63:0] d;
    logic [4:0]  t;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_tag;
  logic [1:0]  occupancy;

  // NUM_OPS=1 / WIDTH=32 instance, ALU always ready
  logic        s1_in_valid, s1_in_ready, s1_out_valid;
  logic [31:0] s1_in_data, s1_out_data;
  logic [4:0]  s1_in_tag, s1_out_tag;
  logic [1:0]  s1_occ;

  // NUM_OPS=3 / WIDTH=16 / TAG_W=4 instance, ALU always ready
  logic        s3_in_valid, s3_in_ready, s3_out_valid;
  logic [47:0] s3_in_data, s3_out_data;
  logic [3:0]  s3_in_tag, s3_out_tag;
  logic [1:0]  s3_occ;

  int vectors;
  int miscompares;

  alu_operand_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .occupancy(occupancy)
  );

  alu_operand_stage #(.WIDTH(32), .NUM_OPS(1), .TAG_W(5)) dut1 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_data(s1_in_data), .in_tag(s1_in_tag),
    .out_valid(s1_out_valid), .out_ready(1'b1), .out_data(s1_out_data), .out_tag(s1_out_tag),
    .occupancy(s1_occ)
  );

  alu_operand_stage #(.WIDTH(16), .NUM_OPS(3), .TAG_W(4)) dut3 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(s3_in_valid), .in_ready(s3_in_ready), .in_data(s3_in_data), .in_tag(s3_in_tag),
    .out_valid(s3_out_valid), .out_ready(1'b1), .out_data(s3_out_data), .out_tag(s3_out_tag),
    .occupancy(s3_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_tag = '0;
    s1_in_valid = 1'b0; s1_in_data = '0; s1_in_tag = '0;
    s3_in_valid = 1'b0; s3_in_data = '0; s3_in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (occupancy !== 2'd0) begin miscompares++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    vectors++; if (out_data !== 64'h0) begin miscompares++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    vectors++; if (out_tag !== 5'h0) begin miscompares++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
    vectors++; if (s1_out_valid !== 1'b0 || s3_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_sweep_valid: got %b%b expected 00", s1_out_valid, s3_out_valid); end
    vectors++; if (s3_out_data !== 48'h0) begin miscompares++; $display("FAIL reset_sweep_data: got %h expected 0", s3_out_data); end
    rst = 1'b0;  // released mid-cycle, away from the edge
    tick();
  endtask

  task automatic test_stream();
    logic [63:0] sent_d;
    logic [4:0]  sent_t;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sent_d = {32'h0000_0002 + 32'(i), 32'h0000_0001 + 32'(i)};
      sent_t = 5'(3 + i);
      in_data = sent_d; in_tag = sent_t;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready); end
      tick();
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_out_valid[%0d]: got %b expected 1", i, out_valid); end
      vectors++; if (out_data !== sent_d) begin miscompares++; $display("FAIL stream_out_data[%0d]: got %h expected %h", i, out_data, sent_d); end
      vectors++; if (out_tag !== sent_t) begin miscompares++; $display("FAIL stream_out_tag[%0d]: got %h expected %h", i, out_tag, sent_t); end
      vectors++; if (occupancy !== 2'd1) begin miscompares++; $display("FAIL stream_occupancy[%0d]: got %0d expected 1", i, occupancy); end
    end
    in_valid = 1'b0;
    tick();
    vectors++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain: got occ=%0d valid=%b expected 0/0", occupancy, out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = {8{8'h11}}; in_tag = 5'd1;
    tick();
    vectors++; if (occupancy !== 2'd1) begin miscompares++; $display("FAIL bp_occ_a: got %0d expected 1", occupancy); end
    vectors++; if (out_data !== {8{8'h11}}) begin miscompares++; $display("FAIL bp_data_a: got %h expected %h", out_data, {8{8'h11}}); end
    in_data = {8{8'h22}}; in_tag = 5'd2;
    tick();
    vectors++; if (occupancy !== 2'd2) begin miscompares++; $display("FAIL bp_occ_full: got %0d expected 2", occupancy); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    vectors++; if (out_data !== {8{8'h11}} || out_tag !== 5'd1) begin miscompares++; $display("FAIL bp_hold_a: got %h/%h expected %h/01", out_data, out_tag, {8{8'h11}}); end
    // Offered while full: must be refused.
    in_data = {8{8'h33}}; in_tag = 5'd3;
    tick();
    vectors++; if (occupancy !== 2'd2 || out_data !== {8{8'h11}}) begin miscompares++; $display("FAIL bp_stall: got occ=%0d data=%h expected 2/%h", occupancy, out_data, {8{8'h11}}); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    vectors++; if (occupancy !== 2'd1 || out_data !== {8{8'h22}} || out_tag !== 5'd2) begin miscompares++; $display("FAIL bp_drain_b: got occ=%0d data=%h tag=%h expected 1/%h/02", occupancy, out_data, out_tag, {8{8'h22}}); end
    tick();
    vectors++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty: got occ=%0d valid=%b expected 0/0", occupancy, out_valid); end
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t e;
    bit   exp_in_fire, exp_out_fire;
    void'($urandom(32'd1234));
    for (int c = 0; c < 1000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 49) == 0);
      in_data   = {$urandom, $urandom};
      in_tag    = 5'($urandom_range(0, 31));
      #1;
      vectors++; if (occupancy !== 2'(q.size())) begin miscompares++; $display("FAIL rand_occ[%0d]: got %0d expected %0d", c, occupancy, q.size()); end
      vectors++; if (in_ready !== (q.size() != 2)) begin miscompares++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", c, in_ready, q.size() != 2); end
      vectors++; if (out_valid !== (q.size() != 0)) begin miscompares++; $display("FAIL rand_out_valid[%0d]: got %b expected %b", c, out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        vectors++; if (out_data !== q[0].d || out_tag !== q[0].t) begin miscompares++; $display("FAIL rand_payload[%0d]: got %h/%h expected %h/%h", c, out_data, out_tag, q[0].d, q[0].t); end
      end
      exp_in_fire  = in_valid && (q.size() < 2);
      exp_out_fire = (q.size() != 0) && out_ready;
      e.d = in_data; e.t = in_tag;
      tick();
      if (flush) begin
        q.delete();
      end else begin
        if (exp_out_fire) void'(q.pop_front());
        if (exp_in_fire) q.push_back(e);
      end
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    vectors++; if (occupancy !== 2'd0) begin miscompares++; $display("FAIL rand_drain: got %0d expected 0", occupancy); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hDDDD_0000_0000_DDDD; in_tag = 5'd4;
    tick();
    in_data = 64'hEEEE_0000_0000_EEEE; in_tag = 5'd5;
    tick();
    vectors++; if (occupancy !== 2'd2) begin miscompares++; $display("FAIL flush_prefill: got %0d expected 2", occupancy); end
    flush = 1'b1; in_data = 64'hFFFF_0000_0000_FFFF; in_tag = 5'd6;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    vectors++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_clear: got occ=%0d valid=%b expected 0/0", occupancy, out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    out_ready = 1'b1;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_no_ghost: got %b expected 0", out_valid); end
    in_valid = 1'b1; in_data = 64'h0123_4567_89AB_CDEF; in_tag = 5'd7;
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_data !== 64'h0123_4567_89AB_CDEF || out_tag !== 5'd7) begin miscompares++; $display("FAIL flush_next: got %b/%h/%h expected 1/0123456789abcdef/07", out_valid, out_data, out_tag); end
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hAAAA_5555_AAAA_5555; in_tag = 5'd9;
    tick();
    in_data = 64'h5555_AAAA_5555_AAAA; in_tag = 5'd10;
    tick();
    in_valid = 1'b0;
    vectors++; if (occupancy !== 2'd2) begin miscompares++; $display("FAIL arst_prefill: got %0d expected 2", occupancy); end
    #3 rst = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_out_valid: got %b expected 0", out_valid); end
    vectors++; if (out_data !== 64'h0 || out_tag !== 5'h0) begin miscompares++; $display("FAIL arst_payload: got %h/%h expected 0/0", out_data, out_tag); end
    vectors++; if (occupancy !== 2'd0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL arst_occ: got occ=%0d ready=%b expected 0/1", occupancy, in_ready); end
    #2 rst = 1'b0;
    tick();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 64'hCAFE_F00D_BEEF_1234; in_tag = 5'd11;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL arst_ready_after: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_data !== 64'hCAFE_F00D_BEEF_1234 || out_tag !== 5'd11) begin miscompares++; $display("FAIL arst_first_input: got %b/%h/%h expected 1/cafef00dbeef1234/0b", out_valid, out_data, out_tag); end
    tick();
  endtask

  task automatic test_lanes();
    s1_in_valid = 1'b1; s1_in_data = 32'hDEAD_BEEF; s1_in_tag = 5'd7;
    s3_in_valid = 1'b1; s3_in_data = {16'hCCCC, 16'hBBBB, 16'hAAAA}; s3_in_tag = 4'hA;
    tick();
    vectors++; if (s1_out_valid !== 1'b1 || s1_out_data !== 32'hDEAD_BEEF || s1_out_tag !== 5'd7) begin miscompares++; $display("FAIL lanes1_a: got %b/%h/%h expected 1/deadbeef/07", s1_out_valid, s1_out_data, s1_out_tag); end
    vectors++; if (s3_out_data[0 +: 16] !== 16'hAAAA) begin miscompares++; $display("FAIL lanes3_k0: got %h expected aaaa", s3_out_data[0 +: 16]); end
    vectors++; if (s3_out_data[16 +: 16] !== 16'hBBBB) begin miscompares++; $display("FAIL lanes3_k1: got %h expected bbbb", s3_out_data[16 +: 16]); end
    vectors++; if (s3_out_data[32 +: 16] !== 16'hCCCC || s3_out_tag !== 4'hA) begin miscompares++; $display("FAIL lanes3_k2: got %h/%h expected cccc/a", s3_out_data[32 +: 16], s3_out_tag); end
    s1_in_data = 32'h1234_5678; s1_in_tag = 5'd8;
    s3_in_data = {16'h3333, 16'h2222, 16'h1111}; s3_in_tag = 4'h5;
    tick();
    s1_in_valid = 1'b0; s3_in_valid = 1'b0;
    vectors++; if (s1_out_data !== 32'h1234_5678 || s1_occ !== 2'd1) begin miscompares++; $display("FAIL lanes1_b: got %h occ=%0d expected 12345678 occ=1", s1_out_data, s1_occ); end
    vectors++; if (s3_out_data !== 48'h3333_2222_1111 || s3_out_tag !== 4'h5) begin miscompares++; $display("FAIL lanes3_b: got %h/%h expected 333322221111/5", s3_out_data, s3_out_tag); end
    tick();
    vectors++; if (s1_out_valid !== 1'b0 || s3_out_valid !== 1'b0) begin miscompares++; $display("FAIL lanes_idle: got %b%b expected 00", s1_out_valid, s3_out_valid); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    test_lanes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
